// File: rtl/fp_normalize_round_if.sv
// Handshake bundle for the FP adder normalise/round stage: operand capture side
// plus packed result side. The block itself uses the slave modport.
interface fp_normalize_round_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic [FRAC_W+4:0]       in_mant;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   out_result;
  logic                    out_overflow;
  logic                    out_underflow;
  logic                    out_zero;
  logic                    out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_zero, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_zero, out_inexact
  );
endinterface

// File: rtl/fp_normalize_round.sv
// Post-add normalise, round-to-nearest-even and pack for the basic FP adder.
// Optional FP_NORM_LZC_FAST_EN: single-cycle leading-zero shift instead of 1 bit/cycle.
module fp_normalize_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_normalize_round_if.slave  io
);
  localparam int MW = FRAC_W + 5;
  localparam int EW = EXP_W + 2;
  localparam int RW = EXP_W + FRAC_W + 1;
  localparam logic [EW-1:0] EXP_ONE = EW'(1);
  localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sign, w_sign_nxt;
  logic [EW-1:0]   r_exp, w_exp_nxt;
  logic [MW-1:0]   r_mant, w_mant_nxt;
  logic [RW-1:0]   r_result, w_result_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            r_unf, w_unf_nxt;
  logic            r_zero, w_zero_nxt;
  logic            r_inx, w_inx_nxt;

  logic              w_lsb, w_g, w_rs, w_inc, w_carry, w_hidden;
  logic [FRAC_W+1:0] w_sig;
  logic [FRAC_W-1:0] w_frac;
  logic [EW-1:0]     w_rexp;

  // Rounding datapath on the registered significand {hidden, frac, G, R|S}
  always_comb begin
    w_lsb    = r_mant[3];
    w_g      = r_mant[2];
    w_rs     = r_mant[1] | r_mant[0];
    w_inc    = w_g & (w_rs | w_lsb);
    w_sig    = {1'b0, r_mant[MW-2:3]} + {{(FRAC_W+1){1'b0}}, w_inc};
    w_carry  = w_sig[FRAC_W+1];
    w_hidden = w_carry | w_sig[FRAC_W];
    w_frac   = w_carry ? '0 : w_sig[FRAC_W-1:0];
    w_rexp   = r_exp + {{(EW-1){1'b0}}, w_carry};
  end

`ifdef FP_NORM_LZC_FAST_EN
  logic [EW-1:0] w_lzc, w_shamt;

  // Distance from the hidden-bit position to the highest set bit below it
  always_comb begin
    w_lzc = EW'(MW - 1);
    for (int unsigned i = 0; i < MW - 1; i++) begin
      if (r_mant[i]) w_lzc = EW'(MW - 2 - i);
    end
    w_shamt = (w_lzc < (r_exp - EXP_ONE)) ? w_lzc : (r_exp - EXP_ONE);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sign_nxt   = r_sign;
    w_exp_nxt    = r_exp;
    w_mant_nxt   = r_mant;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;
    w_zero_nxt   = r_zero;
    w_inx_nxt    = r_inx;
    case (r_state)
      S_IDLE: begin
        if (io.in_valid) begin
          w_sign_nxt  = io.in_sign;
          w_exp_nxt   = (io.in_exp == '0) ? EXP_ONE : {2'b00, io.in_exp};
          w_mant_nxt  = io.in_mant;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_mant[MW-1]) begin
          w_mant_nxt  = {1'b0, r_mant[MW-1:2], r_mant[1] | r_mant[0]};
          w_exp_nxt   = r_exp + EXP_ONE;
          w_state_nxt = S_ROUND;
        end else if (r_mant == '0) begin
          w_result_nxt = '0;
          w_zero_nxt   = 1'b1;
          w_state_nxt  = S_DONE;
        end else if (r_mant[MW-2] || r_exp == EXP_ONE) begin
          w_state_nxt = S_ROUND;
        end else begin
`ifdef FP_NORM_LZC_FAST_EN
          // Shift stops at the same point the iterative loop would: hidden set or exp==1
          w_mant_nxt  = r_mant << w_shamt;
          w_exp_nxt   = r_exp - w_shamt;
          w_state_nxt = S_ROUND;
`else
          w_mant_nxt  = {r_mant[MW-2:0], 1'b0};
          w_exp_nxt   = r_exp - EXP_ONE;
`endif
        end
      end
      S_ROUND: begin
        w_inx_nxt  = w_g | w_rs;
        w_zero_nxt = 1'b0;
        w_ovf_nxt  = 1'b0;
        w_unf_nxt  = 1'b0;
        if (w_rexp >= EXP_MAX) begin
          w_result_nxt = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          w_ovf_nxt    = 1'b1;
        end else if (!w_hidden) begin
          w_result_nxt = {r_sign, {EXP_W{1'b0}}, w_frac};
          w_unf_nxt    = 1'b1;
        end else begin
          w_result_nxt = {r_sign, w_rexp[EXP_W-1:0], w_frac};
        end
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready) begin
          w_ovf_nxt   = 1'b0;
          w_unf_nxt   = 1'b0;
          w_zero_nxt  = 1'b0;
          w_inx_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_zero   <= 1'b0;
      r_inx    <= 1'b0;
    end else begin
      r_sign   <= w_sign_nxt;
      r_exp    <= w_exp_nxt;
      r_mant   <= w_mant_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
      r_zero   <= w_zero_nxt;
      r_inx    <= w_inx_nxt;
    end
  end

  always_comb begin
    io.in_ready      = (r_state == S_IDLE);
    io.out_valid     = (r_state == S_DONE);
    io.out_result    = r_result;
    io.out_overflow  = r_ovf;
    io.out_underflow = r_unf;
    io.out_zero      = r_zero;
    io.out_inexact   = r_inx;
  end
endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed-vector bench for fp_normalize_round: result, flags and latency per vector,
// plus back-pressure and mid-operation reset sequences.
module tb_fp_normalize_round;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  fp_normalize_round_if #(.EXP_W(8), .FRAC_W(23)) bus ();

  fp_normalize_round #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic [31:0] res;
    logic [3:0]  flg;   // {overflow, underflow, zero, inexact}
    int          lat;   // iterative-shifter latency
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int exp_lat(input int lat_iter);
`ifdef FP_NORM_LZC_FAST_EN
    return (lat_iter > 2) ? 2 : lat_iter;
`else
    return lat_iter;
`endif
  endfunction

  function automatic logic [3:0] flags();
    return {bus.out_overflow, bus.out_underflow, bus.out_zero, bus.out_inexact};
  endfunction

  // Accept one operand; returns after the acceptance edge (+1).
  task automatic launch(input logic s, input logic [7:0] e, input logic [27:0] m);
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int hold, input string name);
    int cyc;
    n_vec++;
    launch(v.sign, v.exp, v.mant);
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_latency"}, cyc, exp_lat(v.lat));
    chk({name, "_result"}, bus.out_result, v.res);
    chk({name, "_flags"}, {28'd0, flags()}, {28'd0, v.flg});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({name, "_hold_ready"}, {31'd0, bus.in_ready}, 32'd0);
      chk({name, "_hold_result"}, bus.out_result, v.res);
      chk({name, "_hold_flags"}, {28'd0, flags()}, {28'd0, v.flg});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, "_retire_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({name, "_retire_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({name, "_retire_flags"}, {28'd0, flags()}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    tv[0]  = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 4'b0000, 2};
    tv[1]  = '{1'b0, 8'd130, 28'h0000008, 32'h35800000, 4'b0000, 25};
    tv[2]  = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002, 4'b0001, 2};
    tv[3]  = '{1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 4'b0001, 2};
    tv[4]  = '{1'b0, 8'd254, 28'h8000000, 32'h7F800000, 4'b1000, 2};
    tv[5]  = '{1'b0, 8'd0,   28'h0000010, 32'h00000002, 4'b0100, 2};
    tv[6]  = '{1'b1, 8'h55,  28'h0000000, 32'h00000000, 4'b0010, 1};
    tv[7]  = '{1'b0, 8'd255, 28'h4000000, 32'h7F800000, 4'b1000, 2};
    tv[8]  = '{1'b1, 8'd127, 28'h4000004, 32'hBF800000, 4'b0001, 2};
    tv[9]  = '{1'b0, 8'd3,   28'h0000100, 32'h00000080, 4'b0100, 4};
    tv[10] = '{1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 4'b0001, 2};
    tv[11] = '{1'b0, 8'd127, 28'h8000006, 32'h40000000, 4'b0001, 2};
    tv[12] = '{1'b0, 8'd120, 28'h0200000, 32'h39800000, 4'b0000, 7};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_result", bus.out_result, 32'd0);
    chk("reset_flags", {28'd0, flags()}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(tv[i], 0, $sformatf("vec%0d", i));

    // Back-pressure: result held for 5 cycles with out_ready low
    run_vec(tv[0], 5, "backpressure");

    // Reset while the cancellation operand is still in flight
    n_vec++;
    launch(tv[1].sign, tv[1].exp, tv[1].mant);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_result", bus.out_result, 32'd0);
    chk("midrst_flags", {28'd0, flags()}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(tv[2], 0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Post-addition stage of the basic FP adder; the counterpart of the alignment/exponent-difference front end.
- Takes the larger operand exponent and the raw 28-bit mantissa sum (carry, hidden, fraction, G/R/S), renormalises, rounds to nearest-even and packs an IEEE-754 single.
- Multi-cycle FSM: one left shift per cycle, valid/ready handshake on both sides.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, fraction field width (mantissa input width = FRAC_W+5)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input operand valid
in_ready  out  1  block can accept (high only in IDLE)
in_sign  in  1  result sign
in_exp  in  EXP_W  larger operand exponent (biased)
in_mant  in  FRAC_W+5  {carry, hidden, frac[22:0], G, R, S}
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  32  packed {sign, exp, frac}
out_overflow  out  1  result saturated to infinity
out_underflow  out  1  result denormal or flushed-to-zero after rounding
out_zero  out  1  exact zero result
out_inexact  out  1  any of G/R/S set at rounding

Behaviour:
- States: IDLE, SHIFT, ROUND, DONE. Reset (async): state=IDLE; in_ready=1; out_valid=0; out_result=0; all flags=0.
- IDLE: in_ready=1; on in_valid&&in_ready, capture sign, exp, mant -> SHIFT. in_exp=0 is captured as 1 (denormal effective exponent).
- SHIFT, evaluated per cycle in priority order:
  - mant[27]=1: mant>>1 with new S = old R|S; exp+1 -> ROUND.
  - mant==0: out_result=32'h00000000 (+0 regardless of sign), out_zero=1 -> DONE.
  - mant[26]=1 -> ROUND.
  - exp==1: no further shift -> ROUND (denormal path).
  - otherwise: mant<<1 (S shifts in 0); exp-1; stay in SHIFT.
- ROUND (RNE):
  - lsb=mant[3], G=mant[2], RS=mant[1]|mant[0].
  - Increment mant[26:3] if G&&(RS||lsb); out_inexact=G|RS.
  - Carry out of bit 26: significand becomes 1.0, exp+1.
  - exp>=255: out_result={sign,8'hFF,23'h0}, out_overflow=1.
  - Else if hidden bit=0: exp field=0, out_underflow=1.
  - Packing: frac=mant[25:3].
  - -> DONE.
- DONE:
  - out_valid=1; result and flags held stable while out_ready=0.
  - On out_valid&&out_ready -> IDLE; flags cleared.
  - in_ready rises the following cycle; no same-cycle accept/retire.
- Latency (acceptance edge to out_valid high): k+2 cycles, k = left shifts performed (0..26); carry/right-shift case is 2; zero case is 1.
- in_exp=255 inputs: treated as overflow (infinity output). NaN handling is upstream.
- rst asserted mid-operation: immediate return to IDLE, in-flight result discarded, outputs at reset values.

Optional Feature:
- FP_NORM_LZC_FAST_EN defined:
  - SHIFT uses a combinational leading-zero counter and shifts by min(lzc, exp-1) in one cycle.
  - Latency is fixed at 2 (1 for zero).
  - Results and flags are bit-identical to the iterative path.
- Not defined: the iterative one-bit-per-cycle shifter described above.

Test Plan:
- 1.0+1.0: exp=127, mant=28'h8000000 -> out_result=32'h40000000, no flags, out_valid 2 cycles after accept.
- Cancellation: exp=130, mant=28'h0000008 -> out_result=32'h35800000 after 23 shifts (latency 25; 2 with FP_NORM_LZC_FAST_EN).
- Tie-to-even and round carry:
  - exp=127, mant=28'h400000C -> 32'h3F800002, out_inexact=1.
  - exp=127, mant=28'h7FFFFFC -> 32'h40000000, out_inexact=1.
- Boundaries:
  - exp=254, mant=28'h8000000 -> 32'h7F800000, out_overflow=1.
  - exp=0, mant=28'h0000010 -> 32'h00000002, out_underflow=1.
  - mant=0, sign=1 -> 32'h00000000, out_zero=1, latency 1.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout; in_ready returns 1 cycle after out_ready handshake.
  - Assert rst during SHIFT -> out_valid=0 and in_ready=1 immediately; next op correct.
